counter: RTL and testbench



---
 rtl/counter.sv | 71 +++++++
 tb/tb_counter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Single-shot countdown timer: a rising edge on start loads COUNT_FROM,
// ready stays low until the count has passed zero.
module counter #(
   parameter int WIDTH      = 8,
   parameter int COUNT_FROM = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             ready,
   output logic [WIDTH-1:0] count
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] CNT  = 1'b1;
   localparam logic [WIDTH-1:0] LOAD = COUNT_FROM[WIDTH-1:0];

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             ready_q, ready_d;
   logic             start_q;
   logic             trig;

   assign trig  = start & ~start_q;
   assign ready = ready_q;
   assign count = count_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ready_d = ready_q;
      unique case (state_q)
         IDLE: begin
            if (trig) begin
               count_d = LOAD;
               ready_d = 1'b0;
               state_d = CNT;
            end
         end
         CNT: begin
            // Triggers are ignored here, including on the final edge.
            if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else begin
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         ready_q <= 1'b1;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ready_q <= ready_d;
         start_q <= start;
      end
   end

endmodule

// File: tb/tb_counter.sv
// Directed vector bench for counter: default build plus a
// WIDTH=1, COUNT_FROM=0 build.
module tb_counter;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       ready;
   logic [7:0] count;
   logic       start_s;
   logic       ready_s;
   logic [0:0] count_s;

   int checks;
   int errors;

   typedef struct {
      logic       st;
      logic       rdy;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   counter #(.WIDTH(8), .COUNT_FROM(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .ready (ready),
      .count (count)
   );

   counter #(.WIDTH(1), .COUNT_FROM(0)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_s),
      .ready (ready_s),
      .count (count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic r,
                      input logic [7:0] c, input logic er,
                      input logic [7:0] ec);
      checks++;
      if (r !== er || c !== ec) begin
         errors++;
         $display("FAIL %s: ready=%b count=%0d, expected ready=%b count=%0d",
                  name, r, c, er, ec);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic s, input logic r, input logic [7:0] c);
      vec_t v;
      v.st  = s;
      v.rdy = r;
      v.cnt = c;
      vecs.push_back(v);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b1;
      start   = 1'b0;
      start_s = 1'b0;

      // basic run
      add(0, 1, 0); add(1, 0, 2); add(1, 0, 1); add(0, 0, 0);
      add(0, 1, 0); add(0, 1, 0);
      // level hold for 10 cycles
      add(1, 0, 2); add(1, 0, 1); add(1, 0, 0); add(1, 1, 0);
      add(1, 1, 0); add(1, 1, 0); add(1, 1, 0); add(1, 1, 0);
      add(1, 1, 0); add(1, 1, 0);
      // fresh edge gives a second run
      add(0, 1, 0); add(1, 0, 2); add(0, 0, 1); add(0, 0, 0);
      add(0, 1, 0);
      // edge during COUNT ignored
      add(1, 0, 2); add(0, 0, 1); add(1, 0, 0); add(1, 1, 0);
      add(0, 1, 0); add(0, 1, 0);
      // edge on the returning edge is not accepted
      add(1, 0, 2); add(0, 0, 1); add(0, 0, 0); add(1, 1, 0);
      add(1, 1, 0); add(0, 1, 0);

      #2 rst_n = 1'b0;
      #1;
      chk("reset_async", ready, count, 1'b1, 8'd0);
      chk("reset_async_s", ready_s, {7'd0, count_s}, 1'b1, 8'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("after_release", ready, count, 1'b1, 8'd0);

      foreach (vecs[i]) begin
         start = vecs[i].st;
         step();
         chk($sformatf("vec%0d", i), ready, count, vecs[i].rdy, vecs[i].cnt);
      end

      // reset mid-count with start held high through release
      start = 1'b1;
      step();
      chk("mid_load", ready, count, 1'b0, 8'd2);
      step();
      chk("mid_cnt1", ready, count, 1'b0, 8'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_reset", ready, count, 1'b1, 8'd0);
      step();
      chk("mid_reset_hold", ready, count, 1'b1, 8'd0);
      rst_n = 1'b1;
      step();
      chk("rerun_load", ready, count, 1'b0, 8'd2);
      step();
      chk("rerun_1", ready, count, 1'b0, 8'd1);
      step();
      chk("rerun_0", ready, count, 1'b0, 8'd0);
      step();
      chk("rerun_done", ready, count, 1'b1, 8'd0);
      step();
      chk("no_retrig", ready, count, 1'b1, 8'd0);
      start = 1'b0;

      // COUNT_FROM=0, WIDTH=1: ready low for exactly one cycle
      step();
      chk("s_idle", ready_s, {7'd0, count_s}, 1'b1, 8'd0);
      start_s = 1'b1;
      step();
      chk("s_busy", ready_s, {7'd0, count_s}, 1'b0, 8'd0);
      step();
      chk("s_done", ready_s, {7'd0, count_s}, 1'b1, 8'd0);
      step();
      chk("s_hold", ready_s, {7'd0, count_s}, 1'b1, 8'd0);
      start_s = 1'b0;
      step();
      start_s = 1'b1;
      step();
      chk("s_busy2", ready_s, {7'd0, count_s}, 1'b0, 8'd0);
      step();
      chk("s_done2", ready_s, {7'd0, count_s}, 1'b1, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
